// File: rtl/cnn_frame_sequencer.sv
// Frame-level controller for the conv/pool + DNN pipeline: gates one frame of pixels,
// waits for the done pulse or a timeout, then holds the datapath in flush.
module cnn_frame_sequencer #(
  parameter int BitSize       = 32,
  parameter int ImageWidth    = 8,
  parameter int FlushCycles   = 2,
  parameter int TimeoutCycles = 1024,
  parameter int FrameCntWidth = 16
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     run,
  input  logic                     abort,
  input  logic                     src_valid,
  input  logic [BitSize-1:0]       src_data,
  output logic                     src_ready,
  input  logic                     pipe_ready,
  input  logic                     pipe_done,
  output logic                     pipe_valid,
  output logic [BitSize-1:0]       pipe_data,
  output logic                     pipe_res_n,
  output logic                     busy,
  output logic                     frame_done,
  output logic [FrameCntWidth-1:0] frame_count,
  output logic                     err_timeout
);

  localparam int NPix = ImageWidth * ImageWidth;
  localparam int PixW = (NPix > 1) ? $clog2(NPix) : 1;
  localparam int ToW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int FlW  = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;

  localparam logic [PixW-1:0] PixLast = PixW'(NPix - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TimeoutCycles - 1);
  localparam logic [FlW-1:0]  FlLast  = FlW'(FlushCycles - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, FLUSH} state_t;

  state_t                   state, state_nx;
  logic [PixW-1:0]          pix_cnt, pix_cnt_nx;
  logic [ToW-1:0]           to_cnt, to_cnt_nx;
  logic [FlW-1:0]           fl_cnt, fl_cnt_nx;
  logic                     frame_done_nx;
  logic [FrameCntWidth-1:0] frame_count_nx;
  logic                     err_timeout_nx;
  logic                     accept;

  assign busy       = (state != IDLE);
  assign src_ready  = (state == LOAD) & pipe_ready;
  assign pipe_valid = src_valid & src_ready;
  assign pipe_data  = src_data;
  assign accept     = pipe_valid;
  // Flush is driven by reset too, so the datapath is cleared while res is high.
  assign pipe_res_n = ~res & (state != FLUSH);

  always_comb begin
    state_nx       = state;
    pix_cnt_nx     = pix_cnt;
    to_cnt_nx      = to_cnt;
    fl_cnt_nx      = '0;
    frame_done_nx  = 1'b0;
    frame_count_nx = frame_count;
    err_timeout_nx = err_timeout;
    case (state)
      IDLE: begin
        if (run) begin
          state_nx   = LOAD;
          pix_cnt_nx = '0;
        end
      end
      LOAD: begin
        if (accept) pix_cnt_nx = pix_cnt + 1'b1;
        if (abort) begin
          state_nx = FLUSH;
        end else if (accept && pix_cnt == PixLast) begin
          state_nx  = WAIT;
          to_cnt_nx = '0;
        end
      end
      WAIT: begin
        to_cnt_nx = to_cnt + 1'b1;
        if (abort) begin
          state_nx = FLUSH;
        end else if (pipe_done) begin
          state_nx       = FLUSH;
          frame_done_nx  = 1'b1;
          frame_count_nx = frame_count + 1'b1;
        end else if (to_cnt == ToLast) begin
          state_nx       = FLUSH;
          err_timeout_nx = 1'b1;
        end
      end
      FLUSH: begin
        fl_cnt_nx = fl_cnt + 1'b1;
        if (fl_cnt == FlLast) begin
          state_nx   = run ? LOAD : IDLE;
          pix_cnt_nx = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      to_cnt      <= '0;
      fl_cnt      <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      pix_cnt     <= pix_cnt_nx;
      to_cnt      <= to_cnt_nx;
      fl_cnt      <= fl_cnt_nx;
      frame_done  <= frame_done_nx;
      frame_count <= frame_count_nx;
      err_timeout <= err_timeout_nx;
    end
  end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer: table of frame scenarios plus
// hand-written reset/idle sequences, with a pixel scoreboard on the pipe side.
module tb_cnn_frame_sequencer;

  localparam int NPIX = 64;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        res, run, abort, src_valid, pipe_ready, pipe_done;
  logic [31:0] src_data, pipe_data;
  logic        src_ready, pipe_valid, pipe_res_n, busy, frame_done, err_timeout;
  logic [1:0]  frame_count;

  cnn_frame_sequencer #(
    .BitSize(32), .ImageWidth(8), .FlushCycles(2), .TimeoutCycles(TO), .FrameCntWidth(2)
  ) dut (
    .clk(clk), .res(res), .run(run), .abort(abort),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .pipe_ready(pipe_ready), .pipe_done(pipe_done), .pipe_valid(pipe_valid),
    .pipe_data(pipe_data), .pipe_res_n(pipe_res_n), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit bp;        // toggle pipe_ready every cycle while loading
    int done_at;   // WAIT cycle (1-based) carrying pipe_done, 0 = never
    int abort_at;  // pixel index presented with abort, -1 = none
    bit run_after; // run level at the end of the frame
    bit exp_done;
    int exp_cnt;
    bit exp_err;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        s_valid, s_ready, s_res_n, s_busy, s_fd, s_err;
  logic [1:0]  s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample at the falling edge, score pixels, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_valid = pipe_valid; s_ready = src_ready; s_res_n = pipe_res_n;
    s_busy  = busy; s_fd = frame_done; s_cnt = frame_count; s_err = err_timeout;
    if (pipe_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pipe_data: got %0h expected no beat", pipe_data);
      end else begin
        chk("pipe_data", pipe_data, exp_q.pop_front());
      end
    end
    if (pipe_ready === 1'b0) chk("src_ready_bp", src_ready, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_flush(input bit ed, input int ec, input bit ee, input bit eb);
    int low = 0;
    int fd  = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) begin
        chk("frame_done", s_fd, ed);
        chk("frame_count", s_cnt, ec);
        chk("err_timeout", s_err, ee);
      end
      fd += int'(s_fd);
      if (s_res_n) break;
      low++;
    end
    chk("flush_len", low, 2);
    chk("frame_done_pulses", fd, ed);
    chk("busy_after_flush", s_busy, eb);
  endtask

  task automatic run_frame(input vec_t v);
    int          acc    = 0;
    int          budget = 0;
    int          total  = (v.abort_at >= 0) ? v.abort_at + 1 : NPIX;
    bit          need   = 1;
    logic [31:0] d      = '0;
    while (acc < total && budget < 2000) begin
      if (need) begin
        d = $urandom;
        exp_q.push_back(d);
        need = 0;
      end
      src_data   = d;
      src_valid  = 1'b1;
      pipe_ready = v.bp ? cyc[0] : 1'b1;
      abort      = (acc == v.abort_at);
      if (!v.run_after && acc == 10) run = 1'b0;
      tick();
      cyc++;
      budget++;
      if (s_valid) begin
        acc++;
        need = 1;
      end
    end
    if (budget >= 2000) chk("load_budget", acc, total);
    src_valid  = 1'b0;
    abort      = 1'b0;
    pipe_ready = 1'b1;
    if (v.abort_at < 0) begin
      for (int k = 1; k <= TO; k++) begin
        pipe_done = (k == v.done_at);
        tick();
        if (k == 1) begin
          chk("wait_src_ready", s_ready, 0);
          chk("wait_busy", s_busy, 1);
        end
        if (k == TO) chk("wait_res_n", s_res_n, 1);
        if (k == v.done_at) break;
      end
      pipe_done = 1'b0;
    end
    check_flush(v.exp_done, v.exp_cnt, v.exp_err, v.run_after);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 10, -1, 1'b1, 1'b1, 1, 1'b0};  // plain frame
    vecs[1] = '{1'b1,  5, -1, 1'b1, 1'b1, 2, 1'b0};  // backpressure
    vecs[2] = '{1'b0, 16, -1, 1'b1, 1'b1, 3, 1'b0};  // done on last timeout cycle
    vecs[3] = '{1'b0,  0, 30, 1'b1, 1'b0, 3, 1'b0};  // abort at pixel 30
    vecs[4] = '{1'b0,  3, -1, 1'b1, 1'b1, 0, 1'b0};  // count wraps
    vecs[5] = '{1'b0,  0, -1, 1'b1, 1'b0, 0, 1'b1};  // timeout
    vecs[6] = '{1'b1,  7, -1, 1'b0, 1'b1, 1, 1'b1};  // run drops mid-frame

    res = 1'b1; run = 1'b0; abort = 1'b0; src_valid = 1'b0; src_data = '0;
    pipe_ready = 1'b1; pipe_done = 1'b0;
    tick(); tick();
    chk("rst_busy", s_busy, 0);
    chk("rst_src_ready", s_ready, 0);
    chk("rst_res_n", s_res_n, 0);
    chk("rst_frame_count", s_cnt, 0);
    chk("rst_err", s_err, 0);
    res = 1'b0;
    tick();
    chk("rel_res_n", s_res_n, 1);
    chk("rel_busy", s_busy, 0);
    run = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Reset in the middle of a frame discards the partial frame and the sticky error.
    run = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      src_data  = 32'(i + 100);
      exp_q.push_back(src_data);
      src_valid = 1'b1;
      tick();
    end
    res = 1'b1;
    #1;
    chk("midrst_res_n", pipe_res_n, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", frame_count, 0);
    chk("midrst_err", err_timeout, 0);
    src_valid = 1'b0;
    tick(); tick();
    res = 1'b0;
    tick();
    chk("postrst_res_n", s_res_n, 1);
    run_frame('{1'b0, 4, -1, 1'b0, 1'b1, 1, 1'b0});

    // abort and pipe_done in IDLE have no effect.
    abort = 1'b1; pipe_done = 1'b1;
    tick();
    abort = 1'b0; pipe_done = 1'b0;
    tick();
    chk("idle_busy", s_busy, 0);
    chk("idle_count", s_cnt, 1);
    chk("idle_frame_done", s_fd, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
